// File: rtl/analyzer_trigger_capture.sv
// Logic-analyzer capture core: divided sampling of CH_NUM channels into a circular RAM,
// with pre-trigger history and AND / OR / sequential trigger evaluation.

module analyzer_trigger_slot #(
   parameter int CH_NUM = 8
) (
   input  logic [10:0]       cond,
   input  logic [CH_NUM-1:0] cur,
   input  logic [CH_NUM-1:0] prev,
   output logic              hit
);
   localparam int IW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

   logic ch_ok, c, p;

   always_comb begin
      ch_ok = ({24'd0, cond[7:0]} < 32'(CH_NUM));
      c     = 1'b0;
      p     = 1'b0;
      if (ch_ok) begin
         c = cur[cond[IW-1:0]];
         p = prev[cond[IW-1:0]];
      end
      case (cond[10:8])
         3'd0:    hit = ch_ok & ~c;
         3'd1:    hit = ch_ok & c;
         3'd2:    hit = ~p & c;
         3'd3:    hit = p & ~c;
         3'd4:    hit = p ^ c;
         default: hit = 1'b0;
      endcase
   end
endmodule

module analyzer_trigger_capture #(
   parameter int CH_NUM     = 8,
   parameter int DEPTH_LOG2 = 10,
   parameter int COND_NUM   = 4,
   parameter int DIV_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [CH_NUM-1:0]     digital_in,
   input  logic                  cfg_we,
   input  logic [3:0]            cfg_addr,
   input  logic [31:0]           cfg_wdata,
   input  logic                  start,
   input  logic                  abort,
   output logic                  busy,
   output logic                  triggered,
   output logic                  done,
   output logic [DEPTH_LOG2-1:0] start_ptr,
   output logic [DEPTH_LOG2-1:0] trig_ptr,
   input  logic [DEPTH_LOG2-1:0] rd_addr,
   output logic [CH_NUM-1:0]     rd_data
);
   localparam int DEPTH = 2**DEPTH_LOG2;
   localparam logic [DEPTH_LOG2-1:0] PRE_MAX = DEPTH_LOG2'(DEPTH-2);

   typedef enum logic [2:0] {S_IDLE, S_PRE, S_ARMED, S_POST, S_DONE} state_t;
   state_t state, state_nxt;

   logic [1:0]                    mode;
   logic [DEPTH_LOG2-1:0]         pre_depth;
   logic [DIV_WIDTH-1:0]          clk_div;
   logic [COND_NUM-1:0][11:0]     slot_cfg;
   logic [COND_NUM-1:0]           slot_en, slot_hit;

   logic [DIV_WIDTH-1:0]          div_cnt;
   logic [DEPTH_LOG2-1:0]         wp, pre_cnt, post_cnt, wr_pre, pre_eff, post_last;
   logic [CH_NUM-1:0]             prev_q, prev_eff;
   logic                          first_tick, tick, cap_tick, cfg_open, cfg_wr, start_go, fire;
   logic [3:0]                    stage, seq_cur, last_en;
   logic                          seq_found, seq_hit;
   logic                          unused_cfg;
   logic [CH_NUM-1:0]             mem [DEPTH];

   assign unused_cfg = ^cfg_wdata;

   // Config is open in IDLE/DONE; a pre_depth write on the start cycle must steer IDLE->PRE/ARMED.
   assign cfg_open  = (state == S_IDLE) || (state == S_DONE);
   assign cfg_wr    = cfg_we && cfg_open;
   assign wr_pre    = (cfg_wdata[DEPTH_LOG2-1:0] > PRE_MAX) ? PRE_MAX : cfg_wdata[DEPTH_LOG2-1:0];
   assign pre_eff   = (cfg_wr && cfg_addr == 4'd1) ? wr_pre : pre_depth;
   assign start_go  = start && !abort && cfg_open;
   assign post_last = PRE_MAX - pre_depth;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode      <= '0;
         pre_depth <= '0;
         clk_div   <= '0;
         slot_cfg  <= '0;
      end else if (cfg_wr) begin
         if (cfg_addr == 4'd0) mode      <= cfg_wdata[1:0];
         if (cfg_addr == 4'd1) pre_depth <= wr_pre;
         if (cfg_addr == 4'd2) clk_div   <= cfg_wdata[DIV_WIDTH-1:0];
         for (int i = 0; i < COND_NUM; i++)
            if ({28'd0, cfg_addr} == 32'(i + 3)) slot_cfg[i] <= cfg_wdata[11:0];
      end
   end

   assign tick     = (div_cnt == clk_div);
   assign cap_tick = tick && busy && !abort;
   assign prev_eff = first_tick ? digital_in : prev_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                   div_cnt <= '0;
      else if (start_go || tick) div_cnt <= '0;
      else                       div_cnt <= div_cnt + 1'b1;
   end

   for (genvar g = 0; g < COND_NUM; g++) begin : g_slot
      analyzer_trigger_slot #(.CH_NUM(CH_NUM)) u_slot (
         .cond (slot_cfg[g][10:0]),
         .cur  (digital_in),
         .prev (prev_eff),
         .hit  (slot_hit[g])
      );
      assign slot_en[g] = slot_cfg[g][11];
   end

   // Sequential mode: current stage is the lowest enabled slot at or above the stage pointer.
   always_comb begin
      seq_cur   = '0;
      seq_hit   = 1'b0;
      seq_found = 1'b0;
      last_en   = '0;
      for (int i = COND_NUM-1; i >= 0; i--)
         if (slot_en[i] && 4'(i) >= stage) begin
            seq_cur   = 4'(i);
            seq_hit   = slot_hit[i];
            seq_found = 1'b1;
         end
      for (int i = 0; i < COND_NUM; i++)
         if (slot_en[i]) last_en = 4'(i);
      case (mode)
         2'd0:    fire = &(slot_hit | ~slot_en);
         2'd1:    fire = |(slot_hit & slot_en);
         2'd2:    fire = seq_found && seq_hit && (seq_cur == last_en);
         default: fire = 1'b1;
      endcase
      if (slot_en == '0) fire = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_DONE: if (start) state_nxt = (pre_eff == '0) ? S_ARMED : S_PRE;
         S_PRE:   if (tick && pre_cnt == pre_depth - 1'b1) state_nxt = S_ARMED;
         S_ARMED: if (tick && fire) state_nxt = S_POST;
         S_POST:  if (tick && post_cnt == post_last) state_nxt = S_DONE;
         default: state_nxt = S_IDLE;
      endcase
      if (abort) state_nxt = S_IDLE;
   end

   always_comb begin
      busy = (state == S_PRE) || (state == S_ARMED) || (state == S_POST);
      done = (state == S_DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp         <= '0;
         pre_cnt    <= '0;
         post_cnt   <= '0;
         stage      <= '0;
         first_tick <= 1'b0;
         prev_q     <= '0;
         triggered  <= 1'b0;
         trig_ptr   <= '0;
         start_ptr  <= '0;
      end else begin
         if (start_go) begin
            wp         <= '0;
            pre_cnt    <= '0;
            post_cnt   <= '0;
            stage      <= '0;
            first_tick <= 1'b1;
            triggered  <= 1'b0;
         end else if (cap_tick) begin
            wp         <= wp + 1'b1;
            prev_q     <= digital_in;
            first_tick <= 1'b0;
            case (state)
               S_PRE:  pre_cnt <= pre_cnt + 1'b1;
               S_ARMED: begin
                  if (fire) begin
                     trig_ptr  <= wp;
                     triggered <= 1'b1;
                  end else if (mode == 2'd2 && seq_hit) begin
                     stage <= seq_cur + 4'd1;
                  end
               end
               S_POST: post_cnt <= post_cnt + 1'b1;
               default: ;
            endcase
         end
         if (abort) triggered <= 1'b0;
         if (state == S_POST && state_nxt == S_DONE) start_ptr <= trig_ptr - pre_depth;
      end
   end

   always_ff @(posedge clk) begin
      if (cap_tick) mem[wp] <= digital_in;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) rd_data <= '0;
      else     rd_data <= mem[rd_addr];
   end
endmodule

// File: tb/tb_analyzer_trigger_capture.sv
// Self-checking bench for analyzer_trigger_capture: per-tick sample tables driven into the core and
// compared with a tick-level reference of the trigger rules and the circular RAM window.

module tb_analyzer_trigger_capture;
   localparam int CH = 8, DL = 6, DEPTH = 64, CN = 4, DW = 16, NT = 600;

   logic          clk = 1'b0, rst;
   logic [CH-1:0] digital_in;
   logic          cfg_we, start, abort;
   logic [3:0]    cfg_addr;
   logic [31:0]   cfg_wdata;
   logic          busy, triggered, done;
   logic [DL-1:0] start_ptr, trig_ptr, rd_addr;
   logic [CH-1:0] rd_data;

   analyzer_trigger_capture #(.CH_NUM(CH), .DEPTH_LOG2(DL), .COND_NUM(CN), .DIV_WIDTH(DW)) dut (
      .clk(clk), .rst(rst), .digital_in(digital_in), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
      .cfg_wdata(cfg_wdata), .start(start), .abort(abort), .busy(busy), .triggered(triggered),
      .done(done), .start_ptr(start_ptr), .trig_ptr(trig_ptr), .rd_addr(rd_addr), .rd_data(rd_data)
   );

   always #5 clk = ~clk;

   int checks = 0, errors = 0;
   logic [7:0]  smp [NT];
   logic [7:0]  rb  [DEPTH];
   int          sh_mode, sh_pre, sh_div;
   logic [11:0] sh_slot [CN];
   int          obs_done, obs_trig;
   logic [DL-1:0] obs_tp, obs_sp;

   function automatic int sat_pre(int v);
      int r = v % DEPTH;
      return (r > DEPTH - 2) ? DEPTH - 2 : r;
   endfunction

   function automatic bit slot_true(logic [11:0] s, logic [7:0] cur, logic [7:0] prev);
      logic [2:0] ci = s[2:0];
      if (s[7:0] >= CH) return 1'b0;
      case (s[10:8])
         3'd0: return !cur[ci];
         3'd1: return cur[ci];
         3'd2: return !prev[ci] && cur[ci];
         3'd3: return prev[ci] && !cur[ci];
         3'd4: return prev[ci] != cur[ci];
         default: return 1'b0;
      endcase
   endfunction

   // First tick index at which the trigger fires; tick 0 compares a sample against itself.
   function automatic int fire_tick();
      int en[$];
      int st = 0;
      logic [7:0] p;
      bit any, all;
      for (int i = 0; i < CN; i++) if (sh_slot[i][11]) en.push_back(i);
      for (int k = sh_pre; k < NT; k++) begin
         p = (k == 0) ? smp[0] : smp[k-1];
         if (en.size() == 0 || sh_mode == 3) return k;
         any = 0; all = 1;
         foreach (en[j]) if (slot_true(sh_slot[en[j]], smp[k], p)) any = 1; else all = 0;
         if (sh_mode == 0 && all) return k;
         if (sh_mode == 1 && any) return k;
         if (sh_mode == 2) begin
            if (slot_true(sh_slot[en[st]], smp[k], p)) st++;
            if (st == en.size()) return k;
         end
      end
      return -1;
   endfunction

   // RAM word at address a after the last tick L: the newest tick that landed there.
   function automatic logic [7:0] exp_ram(int a, int L);
      return smp[L - ((L - a) % DEPTH)];
   endfunction

   task automatic fill_random();
      for (int k = 0; k < NT; k++) smp[k] = 8'($urandom);
   endtask

   task automatic cfg_write(input int addr, input int data, input bit applies);
      @(negedge clk);
      cfg_we = 1'b1; cfg_addr = 4'(addr); cfg_wdata = data;
      @(negedge clk);
      cfg_we = 1'b0;
      if (applies) begin
         if (addr == 0) sh_mode = data & 3;
         else if (addr == 1) sh_pre = sat_pre(data);
         else if (addr == 2) sh_div = data & 'hFFFF;
         else if (addr >= 3 && addr < 3 + CN) sh_slot[addr-3] = data[11:0];
      end
   endtask

   // Starts a capture, feeds smp[k] on the k-th tick edge (junk in between), records
   // the edges at which triggered/done appear, then reads the whole RAM back.
   task automatic run_capture(input bit wr_pre, input int pre_val);
      int d, m;
      if (wr_pre) sh_pre = sat_pre(pre_val);
      @(negedge clk);
      start = 1'b1;
      if (wr_pre) begin cfg_we = 1'b1; cfg_addr = 4'd1; cfg_wdata = pre_val; end
      @(negedge clk);
      start = 1'b0; cfg_we = 1'b0;
      d = sh_div + 1; obs_done = -1; obs_trig = -1; m = 0;
      while (m < 20000) begin
         if (triggered && obs_trig < 0) obs_trig = m;
         if (done) begin obs_done = m; break; end
         if ((m + 1) % d == 0 && (m + 1) / d - 1 < NT) digital_in = smp[(m + 1) / d - 1];
         else digital_in = 8'($urandom);
         @(negedge clk);
         m++;
      end
      obs_tp = trig_ptr; obs_sp = start_ptr;
      for (int a = 0; a < DEPTH; a++) begin
         rd_addr = DL'(a);
         @(negedge clk);
         rb[a] = rd_data;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; cfg_we = 0; cfg_addr = 0; cfg_wdata = 0; start = 0; abort = 0;
      digital_in = 0; rd_addr = 0;
      sh_mode = 0; sh_pre = 0; sh_div = 0;
      for (int i = 0; i < CN; i++) sh_slot[i] = '0;
      repeat (3) @(negedge clk);
      checks++; if ({busy, triggered, done} !== 3'b000) begin errors++; $display("FAIL reset flags: got %b want 000", {busy, triggered, done}); end
      checks++; if (start_ptr !== '0 || trig_ptr !== '0) begin errors++; $display("FAIL reset ptrs: got %0d/%0d want 0/0", start_ptr, trig_ptr); end
      checks++; if (rd_data !== '0) begin errors++; $display("FAIL reset rd_data: got %h want 00", rd_data); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_default();
      int f, L;
      cfg_write(0, 3, 1);
      fill_random();
      run_capture(0, 0);
      f = fire_tick(); L = f + DEPTH - 1 - sh_pre;
      checks++; if (obs_done !== DEPTH) begin errors++; $display("FAIL default done_edge: got %0d want %0d", obs_done, DEPTH); end
      checks++; if (obs_tp !== 6'd0 || obs_sp !== 6'd0) begin errors++; $display("FAIL default ptrs: got %0d/%0d want 0/0", obs_tp, obs_sp); end
      for (int a = 0; a < DEPTH; a++) begin
         checks++; if (rb[a] !== exp_ram(a, L)) begin errors++; $display("FAIL default ram[%0d]: got %h want %h", a, rb[a], exp_ram(a, L)); end
      end
   endtask

   task automatic test_rise();
      int f, L;
      cfg_write(0, 0, 1); cfg_write(1, 16, 1); cfg_write(3, 'hA02, 1);
      fill_random();
      for (int k = 0; k < 40; k++) smp[k][2] = 1'b0;
      smp[40][2] = 1'b1;
      run_capture(0, 0);
      f = fire_tick(); L = f + DEPTH - 1 - sh_pre;
      checks++; if (obs_tp !== 6'd40 || obs_sp !== 6'd24) begin errors++; $display("FAIL rise ptrs: got %0d/%0d want 40/24", obs_tp, obs_sp); end
      checks++; if (rb[40][2] !== 1'b1 || rb[39][2] !== 1'b0) begin errors++; $display("FAIL rise ch2: got %b%b want 10", rb[40][2], rb[39][2]); end
      checks++; if (obs_done !== L + 1) begin errors++; $display("FAIL rise done_edge: got %0d want %0d", obs_done, L + 1); end
      for (int a = 0; a < DEPTH; a++) begin
         checks++; if (rb[a] !== exp_ram(a, L)) begin errors++; $display("FAIL rise ram[%0d]: got %h want %h", a, rb[a], exp_ram(a, L)); end
      end
      // ch2 already high when armed: the first tick must not look like a rise
      cfg_write(1, 0, 1);
      fill_random();
      for (int k = 0; k < 5; k++) smp[k][2] = 1'b1;
      smp[5][2] = 1'b0; smp[6][2] = 1'b0; smp[7][2] = 1'b1;
      run_capture(0, 0);
      checks++; if (obs_tp !== 6'd7) begin errors++; $display("FAIL rise first_tick: got %0d want 7", obs_tp); end
   endtask

   task automatic test_or_and();
      int f, L;
      cfg_write(3, 'h800, 1); cfg_write(4, 'h901, 1); cfg_write(1, 0, 1); cfg_write(0, 1, 1);
      fill_random();
      for (int k = 0; k <= 30; k++) begin smp[k][0] = 1'b1; smp[k][1] = 1'b0; end
      smp[30][1] = 1'b1;
      run_capture(0, 0);
      checks++; if (obs_tp !== 6'd30) begin errors++; $display("FAIL or_high trig_ptr: got %0d want 30", obs_tp); end
      fill_random();
      for (int k = 0; k <= 12; k++) begin smp[k][0] = 1'b1; smp[k][1] = 1'b0; end
      smp[12][0] = 1'b0;
      run_capture(0, 0);
      checks++; if (obs_tp !== 6'd12) begin errors++; $display("FAIL or_low trig_ptr: got %0d want 12", obs_tp); end
      cfg_write(0, 0, 1);
      fill_random();
      for (int k = 0; k < 33; k++) smp[k][0] = 1'b1;
      smp[20][0] = 1'b0; smp[20][1] = 1'b0;
      smp[33][0] = 1'b0; smp[33][1] = 1'b1;
      run_capture(0, 0);
      checks++; if (obs_tp !== 6'd33) begin errors++; $display("FAIL and trig_ptr: got %0d want 33", obs_tp); end
      // out-of-range channel never matches; OR falls through to the rise on ch3
      cfg_write(3, 'h909, 1); cfg_write(4, 'hA03, 1); cfg_write(0, 1, 1);
      cfg_write(1, $urandom_range(0, 20), 1);
      fill_random();
      run_capture(0, 0);
      f = fire_tick(); L = f + DEPTH - 1 - sh_pre;
      checks++; if (obs_tp !== DL'(f)) begin errors++; $display("FAIL or_rand trig_ptr: got %0d want %0d", obs_tp, f % DEPTH); end
      checks++; if (obs_done !== L + 1) begin errors++; $display("FAIL or_rand done_edge: got %0d want %0d", obs_done, L + 1); end
   endtask

   task automatic test_seq();
      int f, L;
      cfg_write(3, 'hA00, 1); cfg_write(4, 'hB01, 1); cfg_write(5, 0, 1); cfg_write(6, 0, 1);
      cfg_write(0, 2, 1); cfg_write(1, 4, 1);
      fill_random();
      for (int k = 0; k < NT; k++) begin smp[k][0] = (k >= 12); smp[k][1] = 1'b1; end
      smp[8][1] = 1'b0; smp[15][1] = 1'b0;
      run_capture(0, 0);
      checks++; if (obs_tp !== 6'd15) begin errors++; $display("FAIL seq trig_ptr: got %0d want 15", obs_tp); end
      for (int i = 0; i < CN; i++)
         cfg_write(3 + i, ($urandom_range(0, 1) << 11) | ($urandom_range(0, 4) << 8) | $urandom_range(0, 7), 1);
      cfg_write(1, $urandom_range(0, 20), 1);
      fill_random();
      run_capture(0, 0);
      f = fire_tick(); L = f + DEPTH - 1 - sh_pre;
      checks++; if (obs_tp !== DL'(f)) begin errors++; $display("FAIL seq_rand trig_ptr: got %0d want %0d", obs_tp, f % DEPTH); end
      checks++; if (obs_done !== L + 1) begin errors++; $display("FAIL seq_rand done_edge: got %0d want %0d", obs_done, L + 1); end
      for (int a = 0; a < DEPTH; a++) begin
         checks++; if (rb[a] !== exp_ram(a, L)) begin errors++; $display("FAIL seq_rand ram[%0d]: got %h want %h", a, rb[a], exp_ram(a, L)); end
      end
   endtask

   task automatic test_clk_div();
      int f, L;
      cfg_write(2, 3, 1); cfg_write(0, 1, 1);
      cfg_write(3, 'hC05, 1); cfg_write(4, 0, 1); cfg_write(5, 0, 1); cfg_write(6, 0, 1);
      cfg_write(1, $urandom_range(0, 30), 1);
      fill_random();
      run_capture(0, 0);
      f = fire_tick(); L = f + DEPTH - 1 - sh_pre;
      checks++; if (obs_done - obs_trig !== 4 * (DEPTH - 1 - sh_pre)) begin errors++; $display("FAIL div post_len: got %0d want %0d", obs_done - obs_trig, 4 * (DEPTH - 1 - sh_pre)); end
      checks++; if (obs_done !== (L + 1) * 4) begin errors++; $display("FAIL div done_edge: got %0d want %0d", obs_done, (L + 1) * 4); end
      checks++; if (obs_tp !== DL'(f)) begin errors++; $display("FAIL div trig_ptr: got %0d want %0d", obs_tp, f % DEPTH); end
      for (int a = 0; a < DEPTH; a++) begin
         checks++; if (rb[a] !== exp_ram(a, L)) begin errors++; $display("FAIL div ram[%0d]: got %h want %h", a, rb[a], exp_ram(a, L)); end
      end
   endtask

   task automatic test_boundaries();
      cfg_write(2, 0, 1); cfg_write(0, 3, 1); cfg_write(1, 63, 1);
      fill_random();
      run_capture(0, 0);
      checks++; if (obs_tp !== 6'd62 || obs_sp !== 6'd0) begin errors++; $display("FAIL sat ptrs: got %0d/%0d want 62/0", obs_tp, obs_sp); end
      checks++; if (obs_done !== DEPTH) begin errors++; $display("FAIL sat done_edge: got %0d want %0d", obs_done, DEPTH); end
      fill_random();
      run_capture(1, 5);
      checks++; if (obs_tp !== 6'd5 || obs_sp !== 6'd0) begin errors++; $display("FAIL cfg_start ptrs: got %0d/%0d want 5/0", obs_tp, obs_sp); end
      checks++; if (obs_done !== DEPTH) begin errors++; $display("FAIL cfg_start done_edge: got %0d want %0d", obs_done, DEPTH); end
   endtask

   task automatic test_abort_reset();
      int n;
      cfg_write(0, 0, 1); cfg_write(1, 0, 1); cfg_write(3, 'hD00, 1);
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (20) @(negedge clk);
      checks++; if (busy !== 1'b1 || triggered !== 1'b0) begin errors++; $display("FAIL armed hold: got busy=%b trig=%b want 1/0", busy, triggered); end
      cfg_write(0, 3, 0);
      @(negedge clk); abort = 1'b1; start = 1'b1;
      @(negedge clk); abort = 1'b0; start = 1'b0;
      checks++; if ({busy, triggered, done} !== 3'b000) begin errors++; $display("FAIL abort_start: got %b want 000", {busy, triggered, done}); end
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (300) @(negedge clk);
      checks++; if (busy !== 1'b1 || triggered !== 1'b0) begin errors++; $display("FAIL busy_cfg_dropped: got busy=%b trig=%b want 1/0", busy, triggered); end
      @(negedge clk); abort = 1'b1;
      @(negedge clk); abort = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort: got busy=%b want 0", busy); end
      cfg_write(0, 3, 1);
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      n = 0;
      while (!triggered && n < 100) begin @(negedge clk); n++; end
      repeat (3) @(negedge clk);
      checks++; if (busy !== 1'b1 || triggered !== 1'b1) begin errors++; $display("FAIL post_reached: got busy=%b trig=%b want 1/1", busy, triggered); end
      #1 rst = 1'b1;
      #1;
      checks++; if ({busy, triggered, done, start_ptr, trig_ptr, rd_data} !== '0) begin errors++; $display("FAIL async_rst: got %b/%b/%b/%0d/%0d/%h want all 0", busy, triggered, done, start_ptr, trig_ptr, rd_data); end
      @(negedge clk); rst = 1'b0;
      sh_mode = 0; sh_pre = 0; sh_div = 0;
      for (int i = 0; i < CN; i++) sh_slot[i] = '0;
   endtask

   initial begin
      test_reset();
      test_default();
      test_rise();
      test_or_and();
      test_seq();
      test_clk_div();
      test_boundaries();
      test_abort_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
